// File: rtl/sdram_memtest.sv
// SDRAM memory tester: fills the word range with a 16-bit Galois LFSR pattern, reads it back,
// checks every word, and repeats forever with the next seed. Counts go to the debug display.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | wait for the controller to finish initialisation
// S_WRITE | write the pattern to addresses 0..LAST_ADDR, one per accept
// S_READ  | issue reads 0..LAST_ADDR, throttled by the outstanding limit
// S_DRAIN | wait for the remaining responses, then start the next pass
// S_STOP  | halted after a mismatch (STOP_ON_ERROR); only reset leaves
module sdram_memtest #(
  parameter int                    ADDR_WIDTH      = 22,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR       = 22'h3FFFFF,
  parameter logic [15:0]           SEED            = 16'hACE1,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter bit                    STOP_ON_ERROR   = 1'b0
) (
  input  logic                  dram_clk,
  input  logic                  reset_n,
  input  logic                  ctrl_ready,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [15:0]           req_wdata,
  input  logic                  rsp_valid,
  input  logic [15:0]           rsp_rdata,
  output logic [15:0]           pass_count,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr,
  output logic                  unexpected_rsp,
  output logic                  stopped,
  output logic [15:0]           debug_number
);

  localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_STOP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [15:0]           wr_lfsr;
  logic [15:0]           rd_lfsr;
  logic [15:0]           pass_seed;
  logic [3:0]            outstanding;
  logic [3:0]            out_nxt;
  logic                  cmp_valid;
  logic                  cmp_bad;
  logic                  stop_pend;
  logic                  fail_seen;
  logic                  acc;
  logic                  rd_acc;
  logic                  rsp_live;
  logic                  mismatch;
  logic                  stop_nxt;
  logic                  at_last;
  logic                  rd_issue;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign req_addr  = addr;
  assign req_wdata = wr_lfsr;

  always_comb begin
    acc      = req_valid & req_ready;
    rd_acc   = acc & ~req_write;
    rsp_live = rsp_valid & (outstanding != 4'd0);
    mismatch = rsp_live & (rsp_rdata != rd_lfsr);
    out_nxt  = outstanding + 4'(rd_acc) - 4'(rsp_live);
    stop_nxt = stop_pend | (STOP_ON_ERROR & mismatch);
    at_last  = (addr == LAST_ADDR);
    // a stalled read keeps req_valid up so the handshake never retracts
    rd_issue = (req_valid & ~req_ready) | ((out_nxt < MAX_OS) & ~stop_nxt);
  end

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      req_valid       <= 1'b0;
      req_write       <= 1'b0;
      addr            <= '0;
      rsp_addr        <= '0;
      cmp_addr        <= '0;
      wr_lfsr         <= 16'h0000;
      rd_lfsr         <= 16'h0000;
      pass_seed       <= SEED;
      outstanding     <= 4'd0;
      cmp_valid       <= 1'b0;
      cmp_bad         <= 1'b0;
      stop_pend       <= 1'b0;
      fail_seen       <= 1'b0;
      pass_count      <= 16'h0000;
      error_count     <= 16'h0000;
      first_fail_addr <= '0;
      unexpected_rsp  <= 1'b0;
      stopped         <= 1'b0;
      debug_number    <= 16'h0000;
    end else begin
      outstanding <= out_nxt;
      stop_pend   <= stop_nxt;
      cmp_valid   <= rsp_live;
      cmp_bad     <= mismatch;
      cmp_addr    <= rsp_addr;
      if (rsp_valid && outstanding == 4'd0)
        unexpected_rsp <= 1'b1;
      if (rsp_live) begin
        rd_lfsr  <= lfsr_step(rd_lfsr);
        rsp_addr <= rsp_addr + 1'b1;
      end
      // counters follow the compare by one cycle
      if (cmp_valid && cmp_bad) begin
        if (error_count != 16'hFFFF)
          error_count <= error_count + 16'd1;
        if (!fail_seen) begin
          fail_seen       <= 1'b1;
          first_fail_addr <= cmp_addr;
        end
      end
      debug_number <= {pass_count[7:0], (error_count > 16'd255) ? 8'hFF : error_count[7:0]};

      case (state)
        S_IDLE: begin
          if (ctrl_ready) begin
            state     <= S_WRITE;
            req_valid <= 1'b1;
            req_write <= 1'b1;
            addr      <= '0;
            wr_lfsr   <= pass_seed;
            rd_lfsr   <= pass_seed;
          end
        end
        S_WRITE: begin
          if (acc) begin
            wr_lfsr <= lfsr_step(wr_lfsr);
            if (at_last) begin
              state     <= S_READ;
              addr      <= '0;
              rsp_addr  <= '0;
              req_write <= 1'b0;
              req_valid <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        S_READ: begin
          if (acc && at_last) begin
            state     <= S_DRAIN;
            addr      <= '0;
            req_valid <= 1'b0;
          end else begin
            if (acc)
              addr <= addr + 1'b1;
            req_valid <= rd_issue;
          end
          if (stop_pend && outstanding == 4'd0 && !cmp_valid && !req_valid) begin
            state     <= S_STOP;
            stopped   <= 1'b1;
            req_valid <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (outstanding == 4'd0 && !cmp_valid) begin
            if (stop_pend) begin
              state   <= S_STOP;
              stopped <= 1'b1;
            end else begin
              // wr_lfsr already sits one step past the last written word: the next seed
              state      <= S_WRITE;
              pass_count <= pass_count + 16'd1;
              pass_seed  <= wr_lfsr;
              rd_lfsr    <= wr_lfsr;
              addr       <= '0;
              req_valid  <= 1'b1;
              req_write  <= 1'b1;
            end
          end
        end
        S_STOP: begin
          req_valid <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_memtest.sv
// Bench for sdram_memtest: scoreboarded echo memory on a 4-word range (DUT A) plus a
// stop-on-error instance (DUT B) behind a fixed-latency faulty memory.
module tb_sdram_memtest;

  localparam int AW = 22;

  logic dram_clk = 1'b0;
  always #5 dram_clk = ~dram_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // DUT A: LAST_ADDR=3, MAX_OUTSTANDING=2, no stop
  logic          rstn_a, rdy_a, rv_a, rr_a, rw_a, sv_a, ur_a, st_a;
  logic [AW-1:0] ra_a, ff_a;
  logic [15:0]   rwd_a, sd_a, pc_a, ec_a, dn_a;

  sdram_memtest #(.ADDR_WIDTH(AW), .LAST_ADDR(22'd3), .SEED(16'hACE1),
                  .MAX_OUTSTANDING(2), .STOP_ON_ERROR(1'b0)) dut_a (
    .dram_clk(dram_clk), .reset_n(rstn_a), .ctrl_ready(rdy_a),
    .req_valid(rv_a), .req_ready(rr_a), .req_write(rw_a), .req_addr(ra_a), .req_wdata(rwd_a),
    .rsp_valid(sv_a), .rsp_rdata(sd_a), .pass_count(pc_a), .error_count(ec_a),
    .first_fail_addr(ff_a), .unexpected_rsp(ur_a), .stopped(st_a), .debug_number(dn_a));

  // DUT B: LAST_ADDR=3, MAX_OUTSTANDING=4, stop on error
  logic          rstn_b, rdy_b, rv_b, rr_b, rw_b, sv_b, ur_b, st_b;
  logic [AW-1:0] ra_b, ff_b;
  logic [15:0]   rwd_b, sd_b, pc_b, ec_b, dn_b;

  sdram_memtest #(.ADDR_WIDTH(AW), .LAST_ADDR(22'd3), .SEED(16'hACE1),
                  .MAX_OUTSTANDING(4), .STOP_ON_ERROR(1'b1)) dut_b (
    .dram_clk(dram_clk), .reset_n(rstn_b), .ctrl_ready(rdy_b),
    .req_valid(rv_b), .req_ready(rr_b), .req_write(rw_b), .req_addr(ra_b), .req_wdata(rwd_b),
    .rsp_valid(sv_b), .rsp_rdata(sd_b), .pass_count(pc_b), .error_count(ec_b),
    .first_fail_addr(ff_b), .unexpected_rsp(ur_b), .stopped(st_b), .debug_number(dn_b));

  // hand-computed pattern: pass 0 from ACE1, pass 1 from 1C4E
  logic [15:0] hand [8] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C,
                            16'h1C4E, 16'h0E27, 16'hB313, 16'hED89};

  logic [37:0]   exp_wr [$];
  logic [AW-1:0] exp_rd [$];
  int            rq_due [$];
  logic [15:0]   rq_dat [$];
  logic [15:0]   mem_a [4];
  int            cyc_a = 0;
  int            os_a = 0;
  int            max_os_a = 0;
  int            lat_a = 1;
  bit            rand_ready_a = 1'b0;
  bit            fault_a = 1'b0;
  bit            inject_a = 1'b0;
  bit            stalled_a = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [15:0]   prev_wdata;
  logic          prev_write;

  task automatic push_two_passes();
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 4; a++) exp_wr.push_back({AW'(a), hand[p*4+a]});
      for (int a = 0; a < 4; a++) exp_rd.push_back(AW'(a));
    end
  endtask

  // DUT A memory model and monitor
  initial begin
    logic [37:0] e;
    logic [15:0] d;
    sv_a = 1'b0; sd_a = 16'h0000; rr_a = 1'b1;
    forever begin
      @(negedge dram_clk);
      cyc_a++;
      sv_a = 1'b0; sd_a = 16'h0000;
      if (rq_due.size() > 0 && rq_due[0] == cyc_a) begin
        sv_a = 1'b1;
        sd_a = rq_dat.pop_front();
        void'(rq_due.pop_front());
        os_a--;
      end else if (inject_a) begin
        sv_a = 1'b1; sd_a = 16'h1234; inject_a = 1'b0;
      end
      rr_a = (rand_ready_a && rw_a) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled_a && rstn_a) begin
        chk("hold_valid", rv_a, 1);
        chk("hold_addr", ra_a, prev_addr);
        chk("hold_wdata", rwd_a, prev_wdata);
        chk("hold_write", rw_a, prev_write);
      end
      if (rv_a && rr_a && rstn_a) begin
        if (rw_a) begin
          mem_a[ra_a[1:0]] = rwd_a;
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            chk("wr_addr", ra_a, e[37:16]);
            chk("wr_data", rwd_a, e[15:0]);
          end
        end else begin
          if (exp_rd.size() > 0) chk("rd_addr", ra_a, exp_rd.pop_front());
          d = mem_a[ra_a[1:0]];
          if (fault_a && ra_a[1:0] == 2'd2) begin d = 16'h0000; fault_a = 1'b0; end
          rq_due.push_back(cyc_a + lat_a);
          rq_dat.push_back(d);
          os_a++;
          if (os_a > max_os_a) max_os_a = os_a;
        end
      end
      stalled_a  = rv_a && !rr_a && rstn_a;
      prev_addr  = ra_a;
      prev_wdata = rwd_a;
      prev_write = rw_a;
    end
  end

  // DUT B memory: 2-cycle latency, address 2 always reads back 0
  initial begin
    logic [15:0] mem_b [4];
    logic        v0, v1;
    logic [15:0] d0, d1;
    v0 = 1'b0; v1 = 1'b0; d0 = 16'h0; d1 = 16'h0;
    sv_b = 1'b0; sd_b = 16'h0; rr_b = 1'b1;
    forever begin
      @(negedge dram_clk);
      sv_b = v1; sd_b = d1;
      v1 = v0; d1 = d0; v0 = 1'b0;
      if (rv_b && rstn_b) begin
        if (rw_b) mem_b[ra_b[1:0]] = rwd_b;
        else begin
          v0 = 1'b1;
          d0 = (ra_b[1:0] == 2'd2) ? 16'h0000 : mem_b[ra_b[1:0]];
        end
      end
    end
  end

  task automatic wait_pass_a(input logic [15:0] target, input int budget);
    int n = 0;
    while (pc_a != target && n < budget) begin @(negedge dram_clk); n++; end
    chk("pass_wait", pc_a, target);
  endtask

  initial begin
    int n;
    rstn_a = 1'b0; rstn_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
    push_two_passes();
    repeat (3) @(negedge dram_clk);
    chk("rst_req_valid", rv_a, 0);
    chk("rst_pass", pc_a, 0);
    chk("rst_err", ec_a, 0);
    chk("rst_debug", dn_a, 0);
    chk("rst_stopped", st_a, 0);
    chk("rst_wdata", rwd_a, 0);
    rstn_a = 1'b1; rstn_b = 1'b1;
    repeat (2) @(negedge dram_clk);
    chk("idle_no_req", rv_a, 0);
    rdy_a = 1'b1; rdy_b = 1'b1;

    // phase 1: echo memory, always ready, latency 1
    wait_pass_a(16'd2, 300);
    repeat (2) @(negedge dram_clk);
    chk("p1_err", ec_a, 0);
    chk("p1_unexp", ur_a, 0);
    chk("p1_debug", dn_a, 16'h0200);
    chk("p1_max_os", max_os_a, 1);
    chk("p1_wr_left", exp_wr.size(), 0);
    chk("p1_rd_left", exp_rd.size(), 0);

    // reset in the middle of READ
    n = 0;
    while (!(rv_a && !rw_a) && n < 100) begin @(negedge dram_clk); n++; end
    chk("reach_read", rv_a && !rw_a, 1);
    #2 rstn_a = 1'b0;
    #1 chk("rst_mid_read_valid", rv_a, 0);
    rq_due.delete(); rq_dat.delete(); exp_wr.delete(); exp_rd.delete();
    os_a = 0; max_os_a = 0; lat_a = 5; rand_ready_a = 1'b1; fault_a = 1'b1;
    push_two_passes();
    repeat (2) @(negedge dram_clk);
    chk("rst_mid_pass", pc_a, 0);
    rstn_a = 1'b1;

    // phase 2: stalls, latency 5, one corrupted read, one stray response
    n = 0;
    while (!(pc_a == 16'd1 && rv_a && rw_a) && n < 400) begin @(negedge dram_clk); n++; end
    chk("reach_pass1_write", pc_a == 16'd1 && rv_a && rw_a, 1);
    inject_a = 1'b1;
    wait_pass_a(16'd2, 600);
    repeat (2) @(negedge dram_clk);
    chk("p2_err", ec_a, 1);
    chk("p2_first_fail", ff_a, 2);
    chk("p2_unexp", ur_a, 1);
    chk("p2_max_os", max_os_a, 2);
    chk("p2_debug", dn_a, 16'h0201);
    chk("p2_wr_left", exp_wr.size(), 0);
    chk("p2_rd_left", exp_rd.size(), 0);

    // DUT B: stop on first error
    n = 0;
    while (!st_b && n < 300) begin @(negedge dram_clk); n++; end
    chk("b_stopped", st_b, 1);
    chk("b_err", ec_b, 1);
    chk("b_first_fail", ff_b, 2);
    chk("b_pass", pc_b, 0);
    chk("b_unexp", ur_b, 0);
    n = 0;
    repeat (20) begin @(negedge dram_clk); if (rv_b) n++; end
    chk("b_valid_after_stop", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
